// File: rtl/instr_mem_loader_if.sv
// Byte-stream in / instruction-memory write out bundle for instr_mem_loader.
// master = stream source and memory side, slave = the loader itself.
interface instr_mem_loader_if;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    modport master (
        output start, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a header-counted little-endian byte stream into instruction memory; trailer check under LOADER_CKSUM_EN.
// Latency: one write cycle after each 4th accepted byte of a word; never two writes back to back.
// Backpressure: byte_ready low outside HDR/DATA/CKSUM; byte_valid low stalls in place.
module instr_mem_loader #(
    parameter int MAX_WORDS = 64
) (
    input logic               clk,
    input logic               rst,
    instr_mem_loader_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd5;
`ifdef LOADER_CKSUM_EN
    localparam logic [2:0] S_CKSUM = 3'd4;
    localparam logic [2:0] S_END   = S_CKSUM;
`else
    localparam logic [2:0] S_END   = S_DONE;
`endif

    logic [2:0]  state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [6:0]  idx_q, idx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] asm_q, asm_d;
    logic        err_q, err_d;
    logic [7:0]  cks_q, cks_d;
    logic        xfer;

    assign xfer = bus.byte_valid && bus.byte_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        err_d   = err_q;
        cks_d   = cks_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    cks_d   = 8'h00;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    idx_d  = 7'd0;
                    bcnt_d = 2'd0;
                    if (bus.byte_data == 8'h00) begin
                        state_d = S_END;
                    end else if (bus.byte_data > 8'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = bus.byte_data[6:0];
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    // First byte ends up in [7:0] after four right shifts.
                    asm_d  = {bus.byte_data, asm_q[31:8]};
                    cks_d  = cks_q ^ bus.byte_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                idx_d   = idx_q + 7'd1;
                state_d = (idx_d == cnt_q) ? S_END : S_DATA;
            end
`ifdef LOADER_CKSUM_EN
            S_CKSUM: begin
                if (xfer) begin
                    if (bus.byte_data != cks_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (bus.start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    cks_d   = 8'h00;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            idx_q   <= 7'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 32'd0;
            err_q   <= 1'b0;
            cks_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            cks_q   <= cks_d;
        end
    end

`ifdef LOADER_CKSUM_EN
    assign bus.byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CKSUM);
`else
    assign bus.byte_ready = (state_q == S_HDR) || (state_q == S_DATA);
`endif
    assign bus.cpu_hold = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.we       = (state_q == S_WRITE);
    assign bus.waddr    = {idx_q[5:0], 2'b00};
    assign bus.wdata    = asm_q;
    assign bus.done     = (state_q == S_DONE);
    assign bus.err      = err_q;
endmodule
